// File: rtl/ulpi_pkg.sv
// ---------------------------------------------------------------------------
// ulpi_pkg
// Shared definitions for the ULPI link controller: link FSM state encoding,
// TX CMD prefix, RX CMD field positions and RxEvent codes, and a helper that
// builds the TX CMD byte from a PID.
// ---------------------------------------------------------------------------
package ulpi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_CMD,
        ST_TX_DATA,
        ST_TX_STP,
        ST_TURN_RX,
        ST_RX,
        ST_TURN_TX
    } link_state_t;

    // Upper nibble of a TX CMD byte for a "transmit" command (01 + 00).
    localparam logic [3:0] TXCMD_PREFIX_TRANSMIT = 4'b0100;

    // RX CMD byte field positions.
    localparam int LINESTATE_LSB = 0;
    localparam int LINESTATE_MSB = 1;
    localparam int RXEVENT_LSB   = 4;
    localparam int RXEVENT_MSB   = 5;

    // RxEvent codes carried in RX CMD bits [5:4].
    localparam logic [1:0] RXEVENT_ACTIVE = 2'b01;
    localparam logic [1:0] RXEVENT_ERROR  = 2'b11;

    function automatic logic [7:0] make_txcmd(input logic [3:0] pid);
        return {TXCMD_PREFIX_TRANSMIT, pid};
    endfunction

endpackage

// File: rtl/ulpi_tx_shifter.sv
// ---------------------------------------------------------------------------
// ulpi_tx_shifter
// Holds the transmit payload and presents it one byte at a time, byte 0 first.
// Ports:
//   clk, n_rst  : clock, asynchronous active-low reset
//   load        : capture payload, index back to 0 (priority over shift)
//   shift       : advance to the next byte; ignored once on the last byte
//   payload     : TX_BYTES*8 payload, byte 0 in bits [7:0]
//   cur_byte    : byte at the current index
//   last        : current index is TX_BYTES-1
// ---------------------------------------------------------------------------
module ulpi_tx_shifter
    import ulpi_pkg::*;
#(
    parameter int TX_BYTES = 66,
    parameter int IDX_W    = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [TX_BYTES*8-1:0] payload,
    output logic [7:0]            cur_byte,
    output logic                  last
);

    logic [TX_BYTES*8-1:0] sreg;
    logic [IDX_W-1:0]      idx;

    // The index saturates on the last byte instead of wrapping, so an extra
    // shift request can never expose a stale byte.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sreg <= '0;
            idx  <= '0;
        end else if (load) begin
            sreg <= payload;
            idx  <= '0;
        end else if (shift && !last) begin
            sreg <= sreg >> 8;
            idx  <= idx + 1'b1;
        end
    end

    assign cur_byte = sreg[7:0];
    assign last     = (idx == IDX_W'(TX_BYTES - 1));

endmodule

// File: rtl/ulpi_link_ctrl.sv
// ---------------------------------------------------------------------------
// ulpi_link_ctrl
// ULPI link-side controller: sends a TX CMD followed by a fixed-length
// payload under NXT flow control, handles bus turnaround, aborts a transmit
// when the PHY takes the bus, and decodes RX CMD / RX data from the PHY.
// All state and ULPI sampling advance only on clk edges with ulpi_ce=1.
// Ports:
//   clk, n_rst            : clock, asynchronous active-low reset
//   ulpi_ce               : one-cycle enable per ULPI clock edge
//   ulpi_dir/nxt/data_in  : PHY-driven ULPI lines
//   ulpi_data_out/stp     : link-driven ULPI lines
//   tx_start/pid/payload  : transmit request, latched in IDLE
//   tx_busy/done/abort    : transmit status (done/abort are 1-clk pulses)
//   rx_valid/rx_data      : received data byte (rx_valid is a 1-clk pulse)
//   rx_active/linestate   : fields from the most recent RX CMD
//   rx_err                : 1-clk pulse when an RX CMD reports RxError
// ---------------------------------------------------------------------------
module ulpi_link_ctrl
    import ulpi_pkg::*;
#(
    parameter int TX_BYTES = 66,
    parameter int IDX_W    = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  ulpi_ce,
    input  logic                  ulpi_dir,
    input  logic                  ulpi_nxt,
    input  logic [7:0]            ulpi_data_in,
    output logic [7:0]            ulpi_data_out,
    output logic                  ulpi_stp,
    input  logic                  tx_start,
    input  logic [3:0]            tx_pid,
    input  logic [TX_BYTES*8-1:0] tx_payload,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  tx_abort,
    output logic                  rx_valid,
    output logic [7:0]            rx_data,
    output logic                  rx_active,
    output logic                  rx_err,
    output logic [1:0]            linestate
);

    link_state_t state, state_nx;
    logic [7:0]  cmd_byte;
    logic [7:0]  cur_byte;
    logic        last;
    logic        load, shift;
    logic        done_nx, abort_nx, valid_nx, err_nx, rxcmd, rx_clr;
    logic [1:0]  rx_event;

    assign rx_event = ulpi_data_in[RXEVENT_MSB:RXEVENT_LSB];

    ulpi_tx_shifter #(
        .TX_BYTES (TX_BYTES),
        .IDX_W    (IDX_W)
    ) u_shifter (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (load && ulpi_ce),
        .shift    (shift && ulpi_ce),
        .payload  (tx_payload),
        .cur_byte (cur_byte),
        .last     (last)
    );

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        shift    = 1'b0;
        done_nx  = 1'b0;
        abort_nx = 1'b0;
        valid_nx = 1'b0;
        err_nx   = 1'b0;
        rxcmd    = 1'b0;
        rx_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                // PHY ownership of the bus wins over a pending transmit.
                if (ulpi_dir) begin
                    state_nx = ST_TURN_RX;
                end else if (tx_start) begin
                    state_nx = ST_TX_CMD;
                    load     = 1'b1;
                end
            end
            ST_TX_CMD: begin
                if (ulpi_dir) begin
                    state_nx = ST_TURN_RX;
                    abort_nx = 1'b1;
                end else if (ulpi_nxt) begin
                    state_nx = ST_TX_DATA;
                end
            end
            ST_TX_DATA: begin
                if (ulpi_dir) begin
                    state_nx = ST_TURN_RX;
                    abort_nx = 1'b1;
                end else if (ulpi_nxt) begin
                    if (last) begin
                        state_nx = ST_TX_STP;
                    end else begin
                        shift = 1'b1;
                    end
                end
            end
            ST_TX_STP: begin
                state_nx = ST_IDLE;
                done_nx  = 1'b1;
            end
            ST_TURN_RX: begin
                state_nx = ulpi_dir ? ST_RX : ST_TURN_TX;
            end
            ST_RX: begin
                if (!ulpi_dir) begin
                    state_nx = ST_TURN_TX;
                    rx_clr   = 1'b1;
                end else if (ulpi_nxt) begin
                    valid_nx = 1'b1;
                end else begin
                    rxcmd  = 1'b1;
                    err_nx = (rx_event == RXEVENT_ERROR);
                end
            end
            ST_TURN_TX: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Pulses are cleared on every clk so they last one clk even when ulpi_ce
    // is slower than clk.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            cmd_byte  <= '0;
            tx_done   <= 1'b0;
            tx_abort  <= 1'b0;
            rx_valid  <= 1'b0;
            rx_err    <= 1'b0;
            rx_data   <= '0;
            rx_active <= 1'b0;
            linestate <= '0;
        end else begin
            tx_done  <= 1'b0;
            tx_abort <= 1'b0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (ulpi_ce) begin
                state    <= state_nx;
                tx_done  <= done_nx;
                tx_abort <= abort_nx;
                rx_valid <= valid_nx;
                rx_err   <= err_nx;
                if (load) begin
                    cmd_byte <= make_txcmd(tx_pid);
                end
                if (valid_nx) begin
                    rx_data <= ulpi_data_in;
                end
                if (rxcmd) begin
                    linestate <= ulpi_data_in[LINESTATE_MSB:LINESTATE_LSB];
                    rx_active <= (rx_event == RXEVENT_ACTIVE);
                end
                if (rx_clr) begin
                    rx_active <= 1'b0;
                end
            end
        end
    end

    // Link-driven lines are decoded from registered state only.
    always_comb begin
        ulpi_data_out = 8'h00;
        case (state)
            ST_TX_CMD:  ulpi_data_out = cmd_byte;
            ST_TX_DATA: ulpi_data_out = cur_byte;
            default:    ulpi_data_out = 8'h00;
        endcase
    end

    assign ulpi_stp = (state == ST_TX_STP);
    assign tx_busy  = (state == ST_TX_CMD) || (state == ST_TX_DATA) || (state == ST_TX_STP);

endmodule

// File: tb/tb_ulpi_link_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ulpi_link_ctrl
// Scoreboard bench for ulpi_link_ctrl with TX_BYTES=4. Stimulus pushes the
// expected observable events into a queue; a monitor on the falling clock
// edge pops and compares each event the DUT presents.
// ---------------------------------------------------------------------------
module tb_ulpi_link_ctrl;

    localparam int TB_BYTES = 4;

    localparam logic [3:0] K_TX    = 4'd0;
    localparam logic [3:0] K_DONE  = 4'd1;
    localparam logic [3:0] K_ABORT = 4'd2;
    localparam logic [3:0] K_RXV   = 4'd3;
    localparam logic [3:0] K_ERR   = 4'd4;
    localparam logic [3:0] K_STAT  = 4'd5;
    localparam logic [3:0] K_BUSY  = 4'd6;

    typedef struct packed {
        logic [3:0]  kind;
        logic [15:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    logic                  clk = 1'b0;
    logic                  n_rst = 1'b0;
    logic                  ulpi_ce = 1'b0;
    logic                  ulpi_dir = 1'b0;
    logic                  ulpi_nxt = 1'b0;
    logic [7:0]            ulpi_data_in = 8'h00;
    logic [7:0]            ulpi_data_out;
    logic                  ulpi_stp;
    logic                  tx_start = 1'b0;
    logic [3:0]            tx_pid = 4'h0;
    logic [TB_BYTES*8-1:0] tx_payload = '0;
    logic                  tx_busy;
    logic                  tx_done;
    logic                  tx_abort;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_active;
    logic                  rx_err;
    logic [1:0]            linestate;

    ulpi_link_ctrl #(.TX_BYTES(TB_BYTES)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .ulpi_ce       (ulpi_ce),
        .ulpi_dir      (ulpi_dir),
        .ulpi_nxt      (ulpi_nxt),
        .ulpi_data_in  (ulpi_data_in),
        .ulpi_data_out (ulpi_data_out),
        .ulpi_stp      (ulpi_stp),
        .tx_start      (tx_start),
        .tx_pid        (tx_pid),
        .tx_payload    (tx_payload),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx_abort      (tx_abort),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_active     (rx_active),
        .rx_err        (rx_err),
        .linestate     (linestate)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [3:0] k, input logic [15:0] v);
        exp_q.push_back({k, v});
    endtask

    task automatic check_ev(input logic [3:0] k, input logic [15:0] v, input string name);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: got unexpected event val=%h, required no event", name, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                bad++;
                $display("FAIL %s: got kind=%0d val=%h, required kind=%0d val=%h",
                         name, k, v, e.kind, e.val);
            end
        end
    endtask

    // Monitor: sample away from the active edge and compare every presented event.
    logic [2:0] prev_stat = 3'b000;
    logic       prev_busy = 1'b0;
    always @(negedge clk) begin
        if (ulpi_ce && tx_busy && !ulpi_dir)
            check_ev(K_TX, {6'b0, ulpi_nxt, ulpi_stp, ulpi_data_out}, "tx_bus");
        if (tx_done)
            check_ev(K_DONE, {6'b0, ulpi_stp, tx_busy, ulpi_data_out}, "tx_done");
        if (tx_abort)
            check_ev(K_ABORT, {6'b0, ulpi_stp, tx_busy, ulpi_data_out}, "tx_abort");
        if (rx_valid)
            check_ev(K_RXV, {8'b0, rx_data}, "rx_data");
        if (rx_err)
            check_ev(K_ERR, {13'b0, rx_active, linestate}, "rx_err");
        if ({rx_active, linestate} != prev_stat) begin
            check_ev(K_STAT, {13'b0, rx_active, linestate}, "rx_status");
            prev_stat = {rx_active, linestate};
        end
        if (tx_busy != prev_busy) begin
            check_ev(K_BUSY, {15'b0, tx_busy}, "tx_busy");
            prev_busy = tx_busy;
        end
    end

    task automatic check_reset_outputs(input string name);
        logic [24:0] obs;
        obs = {ulpi_data_out, ulpi_stp, tx_busy, tx_done, tx_abort, rx_valid,
               rx_data, rx_active, rx_err, linestate};
        total++;
        if (obs != 25'd0) begin
            bad++;
            $display("FAIL %s: outputs=%h, required 0", name, obs);
        end
    endtask

    // One ULPI cycle: a clk with ce=1 followed by a clk with ce=0.
    task automatic ce_cycle();
        ulpi_ce = 1'b1;
        @(posedge clk);
        #1;
        ulpi_ce = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Transmit with optional hold (nxt=0 for hold_n ce on byte hold_idx),
    // abort (dir=1 on byte abort_idx) or reset (n_rst=0 on byte rst_idx).
    task automatic run_tx(input logic [3:0] pid, input logic [31:0] pl,
                          input int hold_idx, input int hold_n,
                          input int abort_idx, input int rst_idx);
        logic [7:0] cmd;
        logic [7:0] b;
        cmd = {4'b0100, pid};
        tx_pid     = pid;
        tx_payload = pl;
        push(K_BUSY, 16'd1);
        tx_start = 1'b1;
        ulpi_nxt = 1'b0;
        ce_cycle();
        tx_start = 1'b0;
        tx_pid   = 4'hF;
        tx_payload = 32'hFFFF_FFFF;
        push(K_TX, {6'b0, 1'b0, 1'b0, cmd});
        ce_cycle();
        ulpi_nxt = 1'b1;
        push(K_TX, {6'b0, 1'b1, 1'b0, cmd});
        ce_cycle();
        for (int i = 0; i < TB_BYTES; i++) begin
            b = pl[i*8 +: 8];
            if (i == rst_idx) begin
                // Called only while linestate is non-zero, so reset changes it.
                push(K_STAT, 16'd0);
                push(K_BUSY, 16'd0);
                ulpi_nxt = 1'b0;
                n_rst = 1'b0;
                #2;
                check_reset_outputs("reset_mid_tx");
                @(posedge clk);
                #1;
                n_rst = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            if (i == abort_idx) begin
                ulpi_dir = 1'b1;
                ulpi_nxt = 1'b0;
                push(K_ABORT, 16'd0);
                push(K_BUSY, 16'd0);
                ce_cycle();
                ulpi_data_in = 8'hF3;
                ce_cycle();
                ulpi_data_in = 8'h11;
                push(K_STAT, 16'h0005);
                ce_cycle();
                ulpi_dir = 1'b0;
                push(K_STAT, 16'h0001);
                ce_cycle();
                ce_cycle();
                return;
            end
            if (i == hold_idx) begin
                ulpi_nxt = 1'b0;
                for (int h = 0; h < hold_n; h++) begin
                    push(K_TX, {6'b0, 1'b0, 1'b0, b});
                    ce_cycle();
                end
            end
            ulpi_nxt = 1'b1;
            push(K_TX, {6'b0, 1'b1, 1'b0, b});
            ce_cycle();
        end
        ulpi_nxt = 1'b0;
        push(K_TX, {6'b0, 1'b0, 1'b1, 8'h00});
        push(K_DONE, 16'd0);
        push(K_BUSY, 16'd0);
        ce_cycle();
        ce_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Plain transmit, nxt from the second ce in TX_CMD.
        run_tx(4'h3, 32'hDDCC_BBAA, -1, 0, -1, -1);
        // BB held for three ce.
        run_tx(4'h3, 32'hDDCC_BBAA, 1, 3, -1, -1);
        // PHY takes the bus while CC is presented.
        run_tx(4'h3, 32'hDDCC_BBAA, -1, 0, 2, -1);

        // Receive: RX CMD, two data bytes, PHY releases the bus.
        ulpi_dir = 1'b1;
        ulpi_nxt = 1'b0;
        ulpi_data_in = 8'hFF;
        ce_cycle();
        ce_cycle();
        ulpi_data_in = 8'h11;
        push(K_STAT, 16'h0005);
        ce_cycle();
        ulpi_nxt = 1'b1;
        ulpi_data_in = 8'h2D;
        push(K_RXV, 16'h002D);
        ce_cycle();
        ulpi_data_in = 8'h5A;
        push(K_RXV, 16'h005A);
        ce_cycle();
        ulpi_dir = 1'b0;
        ulpi_nxt = 1'b0;
        push(K_STAT, 16'h0001);
        ce_cycle();
        ce_cycle();

        // RxError RX CMD; tx_start during RX must not start a transmit.
        ulpi_dir = 1'b1;
        ulpi_data_in = 8'hFF;
        ce_cycle();
        ce_cycle();
        tx_start = 1'b1;
        ulpi_data_in = 8'h32;
        push(K_ERR, 16'h0002);
        push(K_STAT, 16'h0002);
        ce_cycle();
        ulpi_nxt = 1'b1;
        ulpi_data_in = 8'h77;
        push(K_RXV, 16'h0077);
        ce_cycle();
        ulpi_nxt = 1'b0;
        ulpi_dir = 1'b0;
        ce_cycle();
        tx_start = 1'b0;
        ce_cycle();
        ce_cycle();

        // Reset in TX_DATA, then a fresh transmit starts from byte 0.
        run_tx(4'hA, 32'h4433_2211, -1, 0, -1, 2);
        run_tx(4'hA, 32'h4433_2211, -1, 0, -1, -1);

        repeat (4) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_events: got %0d pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
